// File: rtl/regbank_sequencer.sv
// Shares the single-port 16x32 register bank between writeback, two-read operand fetch and debug.
// Optional REGSEQ_X0_SKIP_EN: operand fetches skip bank reads of x0 and load 0 directly.
module regbank_sequencer #(
  parameter int DBG_STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [3:0]  op_rs1,
  input  logic [3:0]  op_rs2,
  output logic        op_rsp_valid,
  input  logic        op_rsp_ready,
  output logic [31:0] op_rs1_data,
  output logic [31:0] op_rs2_data,
  input  logic        dbg_valid,
  output logic        dbg_ready,
  input  logic        dbg_write,
  input  logic [3:0]  dbg_reg,
  input  logic [31:0] dbg_wdata,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rdata_valid,
  output logic [3:0]  bank_regNum,
  output logic [31:0] bank_dataIn,
  output logic        bank_writeEnable,
  input  logic [31:0] bank_dataOut,
  output logic [1:0]  o_fsm_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD1  = 2'd1;
  localparam logic [1:0] RD2  = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;
  localparam logic [7:0] STARVE_LIMIT = 8'(DBG_STARVE_LIMIT);

  logic [1:0]  r_state;
  logic [3:0]  r_rs1;
  logic [3:0]  r_rs2;
  logic [31:0] r_rs1_data;
  logic [31:0] r_rs2_data;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_rdata_valid;
  logic [7:0]  r_starve_cnt;

  logic        w_wb_gnt;
  logic        w_op_gnt;
  logic        w_dbg_gnt;
  logic        w_dbg_prio;
  logic [3:0]  w_regnum;
  logic [31:0] w_din;
  logic        w_we;

  assign w_dbg_prio = dbg_valid && (r_starve_cnt >= STARVE_LIMIT);

  // Handshakes: a request is taken on the rising edge where its valid and ready
  // are both high; ready is combinational from the valids, at most one is high.
  always_comb begin
    w_wb_gnt  = 1'b0;
    w_op_gnt  = 1'b0;
    w_dbg_gnt = 1'b0;
    if (reset) begin
      if (r_state == IDLE) begin
        if (wb_valid)       w_wb_gnt  = 1'b1;
        else if (w_dbg_prio) w_dbg_gnt = 1'b1;
        else if (op_valid)  w_op_gnt  = 1'b1;
        else if (dbg_valid) w_dbg_gnt = 1'b1;
      end else if (r_state == RSP) begin
        w_wb_gnt = wb_valid;
      end
    end
  end

  always_comb begin
    w_regnum = 4'd0;
    w_din    = 32'd0;
    w_we     = 1'b0;
    if (w_wb_gnt) begin
      w_regnum = wb_reg;
      w_din    = wb_data;
      w_we     = |wb_reg;
    end else if (w_dbg_gnt) begin
      w_regnum = dbg_reg;
      if (dbg_write) begin
        w_din = dbg_wdata;
        w_we  = |dbg_reg;
      end
    end else if (reset && r_state == RD1) begin
      w_regnum = r_rs1;
    end else if (reset && r_state == RD2) begin
      w_regnum = r_rs2;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state           <= IDLE;
      r_rs1             <= 4'd0;
      r_rs2             <= 4'd0;
      r_rs1_data        <= 32'd0;
      r_rs2_data        <= 32'd0;
      r_dbg_rdata       <= 32'd0;
      r_dbg_rdata_valid <= 1'b0;
      r_starve_cnt      <= 8'd0;
    end else begin
      r_dbg_rdata_valid <= w_dbg_gnt && !dbg_write;
      if (w_dbg_gnt && !dbg_write) r_dbg_rdata <= bank_dataOut;

      if (!dbg_valid || w_dbg_gnt)
        r_starve_cnt <= 8'd0;
      else if (r_state == IDLE && r_starve_cnt != 8'hFF)
        r_starve_cnt <= r_starve_cnt + 8'd1;

      case (r_state)
        IDLE: begin
          if (w_op_gnt) begin
            r_rs1 <= op_rs1;
            r_rs2 <= op_rs2;
`ifdef REGSEQ_X0_SKIP_EN
            if (op_rs1 == 4'd0 && op_rs2 == 4'd0) begin
              r_rs1_data <= 32'd0;
              r_rs2_data <= 32'd0;
              r_state    <= RSP;
            end else if (op_rs1 == 4'd0) begin
              r_rs1_data <= 32'd0;
              r_state    <= RD2;
            end else begin
              r_state <= RD1;
            end
`else
            r_state <= RD1;
`endif
          end
        end
        RD1: begin
          r_rs1_data <= bank_dataOut;
`ifdef REGSEQ_X0_SKIP_EN
          if (r_rs2 == 4'd0) begin
            r_rs2_data <= 32'd0;
            r_state    <= RSP;
          end else begin
            r_state <= RD2;
          end
`else
          r_state <= RD2;
`endif
        end
        RD2: begin
          r_rs2_data <= bank_dataOut;
          r_state    <= RSP;
        end
        default: begin
          if (op_rsp_ready) r_state <= IDLE;
        end
      endcase
    end
  end

  assign wb_ready         = w_wb_gnt;
  assign op_ready         = w_op_gnt;
  assign dbg_ready        = w_dbg_gnt;
  assign op_rsp_valid     = (r_state == RSP);
  assign op_rs1_data      = r_rs1_data;
  assign op_rs2_data      = r_rs2_data;
  assign dbg_rdata        = r_dbg_rdata;
  assign dbg_rdata_valid  = r_dbg_rdata_valid;
  assign bank_regNum      = w_regnum;
  assign bank_dataIn      = w_din;
  assign bank_writeEnable = w_we;
  assign o_fsm_state      = r_state;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed bench for regbank_sequencer with a behavioural 16x32 register bank (x0 reads zero).
module tb_regbank_sequencer;

  logic        clk;
  logic        reset;
  logic        wb_valid, wb_ready;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        op_valid, op_ready;
  logic [3:0]  op_rs1, op_rs2;
  logic        op_rsp_valid, op_rsp_ready;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic        dbg_valid, dbg_ready, dbg_write;
  logic [3:0]  dbg_reg;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic        dbg_rdata_valid;
  logic [3:0]  bank_regNum;
  logic [31:0] bank_dataIn;
  logic        bank_writeEnable;
  logic [31:0] bank_dataOut;
  logic [1:0]  o_fsm_state;

  int n_cmp = 0;
  int n_err = 0;

`ifdef REGSEQ_X0_SKIP_EN
  localparam int LAT_RS2_ZERO  = 2;
  localparam int LAT_BOTH_ZERO = 1;
`else
  localparam int LAT_RS2_ZERO  = 3;
  localparam int LAT_BOTH_ZERO = 3;
`endif

  regbank_sequencer #(.DBG_STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1(op_rs1), .op_rs2(op_rs2),
    .op_rsp_valid(op_rsp_valid), .op_rsp_ready(op_rsp_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_write(dbg_write),
    .dbg_reg(dbg_reg), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
    .dbg_rdata_valid(dbg_rdata_valid),
    .bank_regNum(bank_regNum), .bank_dataIn(bank_dataIn),
    .bank_writeEnable(bank_writeEnable), .bank_dataOut(bank_dataOut),
    .o_fsm_state(o_fsm_state)
  );

  // clock / reset-independent environment: clock and the register bank model
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] bank [16];
  initial for (int i = 0; i < 16; i++) bank[i] = 32'd0;
  assign bank_dataOut = (bank_regNum == 4'd0) ? 32'd0 : bank[bank_regNum];
  always @(posedge clk) if (bank_writeEnable && bank_regNum != 4'd0) bank[bank_regNum] <= bank_dataIn;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // driver tasks (all called at a falling edge)
  task automatic clear_inputs();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    op_valid = 0; op_rs1 = 0; op_rs2 = 0; op_rsp_ready = 0;
    dbg_valid = 0; dbg_write = 0; dbg_reg = 0; dbg_wdata = 0;
  endtask

  task automatic wb_write(input logic [3:0] r, input logic [31:0] d);
    wb_valid = 1; wb_reg = r; wb_data = d;
    #1 check("wb_write_ready", wb_ready, 1);
    @(negedge clk);
    wb_valid = 0;
  endtask

  task automatic dbg_access(input logic w, input logic [3:0] r, input logic [31:0] d);
    int t = 0;
    dbg_valid = 1; dbg_write = w; dbg_reg = r; dbg_wdata = d;
    #1;
    while (!dbg_ready && t < 20) begin @(negedge clk); #1; t++; end
    check("dbg_accept", dbg_ready, 1);
    @(negedge clk);
    dbg_valid = 0; dbg_write = 0;
  endtask

  // Returns at the falling edge after the accepting edge, with the FSM in its first read state.
  task automatic op_issue(input logic [3:0] a, input logic [3:0] b);
    int t = 0;
    op_valid = 1; op_rs1 = a; op_rs2 = b;
    #1;
    while (!op_ready && t < 20) begin @(negedge clk); #1; t++; end
    check("op_accept", op_ready, 1);
    @(negedge clk);
    op_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!op_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
  endtask

  task automatic finish_op(input string tag, input int lat, input int exp_lat,
                           input logic [31:0] e1, input logic [31:0] e2);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rs1_data"}, op_rs1_data, e1);
    check({tag, "_rs2_data"}, op_rs2_data, e2);
    @(negedge clk);
    check({tag, "_rsp_hold"}, {op_rsp_valid, op_rs1_data ^ e1}, {1'b1, 32'd0});
    op_rsp_ready = 1;
    @(negedge clk);
    op_rsp_ready = 0;
    check({tag, "_back_idle"}, o_fsm_state, 0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input int exp_lat, input logic [31:0] e1, input logic [31:0] e2);
    int lat;
    op_issue(a, b);
    wait_rsp(lat);
    finish_op(tag, lat, exp_lat, e1, e2);
  endtask

  // IDLE arbitration vectors: applied and checked combinationally, withdrawn before the edge
  typedef struct {
    logic        wb_v;
    logic [3:0]  wb_r;
    logic [31:0] wb_d;
    logic        op_v;
    logic        dbg_v;
    logic        dbg_w;
    logic [3:0]  dbg_r;
    logic [31:0] dbg_d;
    logic [2:0]  exp_rdy;   // {wb, op, dbg}
    logic        exp_we;
    logic [3:0]  exp_num;
    logic [31:0] exp_din;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int lat, n_op, t;
    clear_inputs();
    reset = 0;
    vecs[0] = '{0, 4'd0, 32'h0,        0, 0, 0, 4'd0, 32'h0,      3'b000, 0, 4'd0, 32'h0};
    vecs[1] = '{1, 4'd5, 32'hDEADBEEF, 0, 0, 0, 4'd0, 32'h0,      3'b100, 1, 4'd5, 32'hDEADBEEF};
    vecs[2] = '{1, 4'd6, 32'h11112222, 1, 0, 0, 4'd0, 32'h0,      3'b100, 1, 4'd6, 32'h11112222};
    vecs[3] = '{1, 4'd9, 32'h0BADF00D, 1, 1, 1, 4'd2, 32'h77,     3'b100, 1, 4'd9, 32'h0BADF00D};
    vecs[4] = '{0, 4'd0, 32'h0,        1, 1, 0, 4'd3, 32'h0,      3'b010, 0, 4'd0, 32'h0};
    vecs[5] = '{0, 4'd0, 32'h0,        0, 1, 0, 4'd3, 32'h0,      3'b001, 0, 4'd3, 32'h0};
    vecs[6] = '{0, 4'd0, 32'h0,        0, 1, 1, 4'd7, 32'hA5A5,   3'b001, 1, 4'd7, 32'hA5A5};
    vecs[7] = '{0, 4'd0, 32'h0,        0, 1, 1, 4'd0, 32'h1234,   3'b001, 0, 4'd0, 32'h1234};
    vecs[8] = '{1, 4'd0, 32'h1234,     0, 0, 0, 4'd0, 32'h0,      3'b100, 0, 4'd0, 32'h1234};

    // reset: hold all requests high, nothing may be granted or written
    wb_valid = 1; wb_reg = 4'd4; wb_data = 32'hFFFF; op_valid = 1; dbg_valid = 1; dbg_write = 1; dbg_reg = 4'd6;
    repeat (2) @(negedge clk);
    #1;
    check("rst_readys", {wb_ready, op_ready, dbg_ready}, 3'b000);
    check("rst_we", bank_writeEnable, 0);
    check("rst_state", o_fsm_state, 0);
    check("rst_rsp_valid", op_rsp_valid, 0);
    check("rst_rs_data", {op_rs1_data | op_rs2_data}, 0);
    check("rst_dbg", {dbg_rdata_valid, dbg_rdata}, 0);
    @(negedge clk);
    clear_inputs();
    reset = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      wb_valid = vecs[i].wb_v; wb_reg = vecs[i].wb_r; wb_data = vecs[i].wb_d;
      op_valid = vecs[i].op_v; op_rs1 = 4'd1; op_rs2 = 4'd2;
      dbg_valid = vecs[i].dbg_v; dbg_write = vecs[i].dbg_w;
      dbg_reg = vecs[i].dbg_r; dbg_wdata = vecs[i].dbg_d;
      #1;
      check($sformatf("vec%0d_readys", i), {wb_ready, op_ready, dbg_ready}, vecs[i].exp_rdy);
      check($sformatf("vec%0d_we", i), bank_writeEnable, vecs[i].exp_we);
      check($sformatf("vec%0d_regnum", i), bank_regNum, vecs[i].exp_num);
      check($sformatf("vec%0d_datain", i), bank_dataIn, vecs[i].exp_din);
      #1 clear_inputs();
      @(negedge clk);
    end

    // writeback then operand fetch of it
    wb_write(4'd5, 32'hDEADBEEF);
    run_op("op_5_0", 4'd5, 4'd0, LAT_RS2_ZERO, 32'hDEADBEEF, 32'd0);

    // wb and op together: wb first, op next cycle, op sees wb data
    wb_valid = 1; wb_reg = 4'd7; wb_data = 32'h07770777;
    op_valid = 1; op_rs1 = 4'd7; op_rs2 = 4'd5;
    #1 check("both_first_readys", {wb_ready, op_ready}, 2'b10);
    @(negedge clk);
    wb_valid = 0;
    #1 check("both_second_op_ready", op_ready, 1);
    @(negedge clk);
    op_valid = 0;
    wait_rsp(lat);
    finish_op("op_7_5", lat, 3, 32'h07770777, 32'hDEADBEEF);

    // wb to x0 is accepted but never written; dbg reads
    wb_valid = 1; wb_reg = 4'd0; wb_data = 32'h1234;
    #1 check("wb_x0_ready_we", {wb_ready, bank_writeEnable}, 2'b10);
    @(negedge clk);
    wb_valid = 0;
    dbg_access(0, 4'd5, 32'd0);
    check("dbg_rd5_pulse", dbg_rdata_valid, 1);
    check("dbg_rd5_data", dbg_rdata, 32'hDEADBEEF);
    dbg_access(0, 4'd0, 32'd0);
    check("dbg_rd0_pulse", dbg_rdata_valid, 1);
    check("dbg_rd0_data", dbg_rdata, 32'd0);
    @(negedge clk);
    check("dbg_rd0_pulse_end", dbg_rdata_valid, 0);
    check("dbg_rd0_held", dbg_rdata, 32'd0);

    // debug write of x3, then starvation under continuous op traffic
    dbg_access(1, 4'd3, 32'h55);
    check("dbg_wr_no_pulse", dbg_rdata_valid, 0);
    n_op = 0; t = 0;
    op_valid = 1; op_rs1 = 4'd1; op_rs2 = 4'd2; op_rsp_ready = 1;
    dbg_valid = 1; dbg_write = 0; dbg_reg = 4'd3;
    #1;
    while (!dbg_ready && t < 200) begin
      if (op_ready) n_op++;
      @(negedge clk); #1; t++;
    end
    check("starve_dbg_won", dbg_ready, 1);
    check("starve_losses", n_op, 8);
    @(negedge clk);
    op_valid = 0; dbg_valid = 0; op_rsp_ready = 0;
    check("starve_rd_pulse", dbg_rdata_valid, 1);
    check("starve_rd_data", dbg_rdata, 32'h55);

    run_op("op_3_7", 4'd3, 4'd7, 3, 32'h55, 32'h07770777);

    // reset asserted for two cycles in RD2
    op_issue(4'd5, 4'd3);
    @(negedge clk);
    check("mid_rd2_state", o_fsm_state, 2);
    reset = 0;
    wb_valid = 1; wb_reg = 4'd4; wb_data = 32'hFFFF; op_valid = 1;
    dbg_valid = 1; dbg_write = 1; dbg_reg = 4'd6; dbg_wdata = 32'hEEEE;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("mid_rst%0d_readys", c), {wb_ready, op_ready, dbg_ready}, 3'b000);
      check($sformatf("mid_rst%0d_we", c), bank_writeEnable, 0);
      @(negedge clk);
    end
    clear_inputs();
    reset = 1;
    check("mid_rst_state", o_fsm_state, 0);
    check("mid_rst_rsp_valid", op_rsp_valid, 0);
    check("mid_rst_rs1", op_rs1_data, 0);
    check("mid_rst_rs2", op_rs2_data, 0);
    check("mid_rst_dbg_rdata", dbg_rdata, 0);
    check("mid_rst_no_write", bank[4] | bank[6], 0);
    @(negedge clk);
    check("post_rst_idle_bus", {bank_writeEnable, bank_regNum}, 0);

    // both operands x0
    run_op("op_0_0", 4'd0, 4'd0, LAT_BOTH_ZERO, 32'd0, 32'd0);
    run_op("op_3_5", 4'd3, 4'd5, 3, 32'h55, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
